fixed_point_multiplier: RTL and testbench

- Pipelined signed fixed-point multiplier for the neural-network datapath (neuron weight × activation products).
- Operands and result share one format: FIXED_POINT_LENGTH bits total, FIXED_POINT_POSITION fractional bits, two's complement. Default is Q6.10.
- Full-precision product is rounded back to the operand format, saturated and registered.
- Free-running: a new operand pair may be presented every clock, with no handshake.

---
 rtl/fixed_point_multiplier.sv | 56 +++++
 tb/tb_fixed_point_multiplier.sv | 145 ++++++++++++++
 2 files changed

// File: rtl/fixed_point_multiplier.sv
// Two-stage pipelined signed fixed-point multiplier: operand registers, then
// round-half-up, arithmetic shift and saturation into the result register.
module fixed_point_multiplier #(
  parameter int unsigned FIXED_POINT_LENGTH   = 16,
  parameter int unsigned FIXED_POINT_POSITION = 10
) (
  input  logic                          clk_in,
  input  logic                          rst_in,
  input  logic [FIXED_POINT_LENGTH-1:0] fixed_point_1_in,
  input  logic [FIXED_POINT_LENGTH-1:0] fixed_point_2_in,
  output logic [FIXED_POINT_LENGTH-1:0] product_out
);

  localparam int unsigned L  = FIXED_POINT_LENGTH;
  localparam int unsigned FP = FIXED_POINT_POSITION;
  localparam int unsigned PW = 2 * L;
  localparam int unsigned RW = PW + 1;

  localparam logic signed [RW-1:0] ROUND_C   = RW'(1) << (FP - 1);
  localparam logic signed [RW-1:0] SAT_MAX_C = {{(RW-L+1){1'b0}}, {(L-1){1'b1}}};
  localparam logic signed [RW-1:0] SAT_MIN_C = {{(RW-L+1){1'b1}}, {(L-1){1'b0}}};

  logic signed [L-1:0]  a_q, b_q;
  logic        [L-1:0]  product_q, product_d;
  logic signed [PW-1:0] p_c;
  logic signed [RW-1:0] r_c;
  logic signed [RW-1:0] s_c;

  // Full product, rounded one bit wider than the product so the bias cannot wrap.
  always_comb begin
    p_c       = $signed(PW'(a_q)) * $signed(PW'(b_q));
    r_c       = $signed(RW'(p_c)) + ROUND_C;
    s_c       = r_c >>> FP;
    product_d = s_c[L-1:0];
    if (s_c > SAT_MAX_C) begin
      product_d = SAT_MAX_C[L-1:0];
    end else if (s_c < SAT_MIN_C) begin
      product_d = SAT_MIN_C[L-1:0];
    end
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      a_q       <= '0;
      b_q       <= '0;
      product_q <= '0;
    end else begin
      a_q       <= $signed(fixed_point_1_in);
      b_q       <= $signed(fixed_point_2_in);
      product_q <= product_d;
    end
  end

  assign product_out = product_q;

endmodule

// File: tb/tb_fixed_point_multiplier.sv
// Randomized and directed checks of fixed_point_multiplier against an
// integer-arithmetic reference with a two-edge latency model.
module tb_fixed_point_multiplier;

  localparam int unsigned L  = 16;
  localparam int unsigned FP = 10;

  logic         clk_in = 1'b0;
  logic         rst_in = 1'b1;
  logic [L-1:0] fixed_point_1_in = '0;
  logic [L-1:0] fixed_point_2_in = '0;
  logic [L-1:0] product_out;

  int n_cmp = 0;
  int n_err = 0;

  logic [L-1:0] exp1 = '0;
  logic [L-1:0] exp2 = '0;

  fixed_point_multiplier #(
    .FIXED_POINT_LENGTH  (L),
    .FIXED_POINT_POSITION(FP)
  ) dut (
    .clk_in          (clk_in),
    .rst_in          (rst_in),
    .fixed_point_1_in(fixed_point_1_in),
    .fixed_point_2_in(fixed_point_2_in),
    .product_out     (product_out)
  );

  always #5 clk_in = ~clk_in;

  // Exact real-number semantics: floor((a*b + half_lsb) / 2^FP), then clamp.
  function automatic logic [L-1:0] ref_mul(input logic [L-1:0] a, input logic [L-1:0] b);
    longint pa, pb, r, d, s, lo, hi;
    pa = longint'($signed(a));
    pb = longint'($signed(b));
    d  = longint'(1) << FP;
    r  = pa * pb + d / 2;
    if (r >= 0) s = r / d;
    else        s = -((-r + d - 1) / d);
    hi = (longint'(1) << (L - 1)) - 1;
    lo = -(longint'(1) << (L - 1));
    if (s > hi) s = hi;
    if (s < lo) s = lo;
    return L'(s);
  endfunction

  task automatic check_eq(input string tag, input logic [L-1:0] obs, input logic [L-1:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Present one operand pair, take one edge, compare against the delayed model.
  task automatic step(input string tag, input logic [L-1:0] a, input logic [L-1:0] b);
    fixed_point_1_in = a;
    fixed_point_2_in = b;
    @(posedge clk_in);
    #1;
    if (rst_in) begin
      exp1 = '0;
      exp2 = '0;
    end else begin
      exp2 = exp1;
      exp1 = ref_mul(a, b);
    end
    check_eq(tag, product_out, exp2);
  endtask

  // Hold a pair for two edges, then check against a hand-computed value.
  task automatic directed(input string tag, input logic [L-1:0] a, input logic [L-1:0] b,
                          input logic [L-1:0] lit);
    step(tag, a, b);
    step(tag, a, b);
    check_eq({tag, "_lit"}, product_out, lit);
  endtask

  function automatic logic [L-1:0] rand_operand();
    logic [L-1:0] v;
    case ($urandom_range(0, 5))
      0:       v = 16'h8000;
      1:       v = 16'h7FFF;
      2:       v = 16'h0400;
      3:       v = L'($urandom_range(0, 7)) - L'(3);
      default: v = L'($urandom);
    endcase
    return v;
  endfunction

  initial begin
    #1;
    check_eq("reset_async", product_out, '0);
    repeat (2) @(posedge clk_in);
    #1;
    check_eq("reset_hold", product_out, '0);
    rst_in = 1'b0;

    step("unity_fill", 16'h0400, 16'h0400);
    directed("unity", 16'h0400, 16'h0400, 16'h0400);
    repeat (3) step("unity_hold", 16'h0400, 16'h0400);
    check_eq("unity_hold_lit", product_out, 16'h0400);

    directed("neg_times_two", 16'hFC00, 16'h0800, 16'hF800);
    directed("neg_times_neg", 16'hFC00, 16'hFC00, 16'h0400);
    directed("round_up",      16'h0001, 16'h0200, 16'h0001);
    directed("round_tie_neg", 16'hFFFF, 16'h0200, 16'h0000);
    directed("round_down",    16'h0001, 16'h0100, 16'h0000);
    directed("sat_max",       16'h7FFF, 16'h7FFF, 16'h7FFF);
    directed("sat_min",       16'h8000, 16'h0800, 16'h8000);
    directed("min_times_min", 16'h8000, 16'h8000, 16'h7FFF);
    directed("min_times_one", 16'h8000, 16'h0400, 16'h8000);
    directed("zero",          16'h0000, 16'h7FFF, 16'h0000);

    for (int i = 0; i < 8; i++) begin
      step("burst", L'(16'h0100 * (i + 1)), L'(16'hFE00 + 16'h0180 * i));
    end

    // Reset between edges must clear the output without waiting for a clock.
    step("pre_reset", 16'h0C00, 16'h0800);
    step("pre_reset", 16'h0C00, 16'h0800);
    check_eq("pre_reset_lit", product_out, 16'h1800);
    #3;
    rst_in = 1'b1;
    #1;
    check_eq("reset_mid", product_out, '0);
    step("reset_held", 16'h0C00, 16'h0800);
    #2;
    rst_in = 1'b0;
    step("post_reset_e1", 16'h0C00, 16'h0800);
    check_eq("post_reset_e1_lit", product_out, 16'h0000);
    step("post_reset_e2", 16'h0C00, 16'h0800);
    check_eq("post_reset_e2_lit", product_out, 16'h1800);

    for (int i = 0; i < 400; i++) begin
      step("random", rand_operand(), rand_operand());
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
